// File: rtl/pipe_fp_summator.sv
// Three-stage pipelined floating-point adder (align / add / normalise-round) with valid/ready flow.
// Define FP_SUM_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module pipe_fp_summator #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [EXP_W+MANT_W:0]     a_i,
    input  logic [EXP_W+MANT_W:0]     b_i,
    input  logic                      vld_i,
    output logic                      rdy_o,
    output logic [EXP_W+MANT_W:0]     sum_o,
    output logic [1:0]                status_o,
    output logic                      vld_o,
    input  logic                      rdy_i
);

    localparam int W   = 1 + EXP_W + MANT_W;
    localparam int MW  = MANT_W + 1;
    localparam int XW  = MANT_W + 4;
    localparam int SW  = MANT_W + 5;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(XW + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_INF = 2'b01;
    localparam logic [1:0] ST_NAN = 2'b10;

    localparam logic signed [EW-1:0] EXP_INC  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ONES = EW'((1 << EXP_W) - 1);

    logic en;

    // ------------------------------------------------------------------ S1 align
    logic              a_sign, b_sign, a_zero, b_zero;
    logic              a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0]  a_exp, b_exp, big_exp, small_exp, d;
    logic [MANT_W-1:0] a_frac, b_frac;
    logic [MW-1:0]     a_mant, b_mant, big_mant, small_mant;
    logic [W-2:0]      a_mag, b_mag;
    logic [XW-1:0]     small_ext, shifted, small_al;
    logic              lost, big_sign;

    logic              s1_vld_d, s1_sign_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_zsign_d;
    logic [EXP_W-1:0]  s1_exp_d;
    logic [MW-1:0]     s1_big_d;
    logic [XW-1:0]     s1_small_d;

    logic              s1_vld_q, s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_zsign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MW-1:0]     s1_big_q;
    logic [XW-1:0]     s1_small_q;

    always_comb begin
        a_sign = a_i[W-1];
        b_sign = b_i[W-1];
        a_exp  = a_i[W-2:MANT_W];
        b_exp  = b_i[W-2:MANT_W];
        a_frac = a_i[MANT_W-1:0];
        b_frac = b_i[MANT_W-1:0];

        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_nan  = (a_exp == '1) && (a_frac != '0);
        b_nan  = (b_exp == '1) && (b_frac != '0);
        a_inf  = (a_exp == '1) && (a_frac == '0);
        b_inf  = (b_exp == '1) && (b_frac == '0);

        // Denormals are flushed: zero magnitude and no hidden bit.
        a_mag  = a_zero ? '0 : a_i[W-2:0];
        b_mag  = b_zero ? '0 : b_i[W-2:0];
        a_mant = a_zero ? '0 : {1'b1, a_frac};
        b_mant = b_zero ? '0 : {1'b1, b_frac};

        swap = (b_mag > a_mag);
        if (swap) begin
            big_sign   = b_sign;
            big_exp    = b_exp;
            big_mant   = b_mant;
            small_exp  = a_exp;
            small_mant = a_mant;
        end else begin
            big_sign   = a_sign;
            big_exp    = a_exp;
            big_mant   = a_mant;
            small_exp  = b_exp;
            small_mant = b_mant;
        end

        d         = big_exp - small_exp;
        small_ext = {small_mant, 3'b000};
        shifted   = '0;
        lost      = 1'b0;
        if (32'(d) > XW - 1) begin
            small_al = {{(XW-1){1'b0}}, |small_mant};
        end else begin
            shifted  = small_ext >> d;
            lost     = |(small_ext & ~({XW{1'b1}} << d));
            small_al = {shifted[XW-1:1], shifted[0] | lost};
        end

        // Inf/NaN out-rank every finite magnitude, so big_sign is already the Inf sign.
        s1_vld_d   = vld_i;
        s1_sign_d  = big_sign;
        s1_sub_d   = a_sign ^ b_sign;
        s1_exp_d   = big_exp;
        s1_big_d   = big_mant;
        s1_small_d = small_al;
        s1_nan_d   = a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
        s1_inf_d   = (a_inf | b_inf) & ~s1_nan_d;
        s1_zsign_d = a_sign & b_sign;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_big_q   <= '0;
            s1_small_q <= '0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zsign_q <= 1'b0;
        end else if (en) begin
            s1_vld_q   <= s1_vld_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_exp_q   <= s1_exp_d;
            s1_big_q   <= s1_big_d;
            s1_small_q <= s1_small_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zsign_q <= s1_zsign_d;
        end
    end

    // ------------------------------------------------------------------ S2 add
    logic [SW-1:0]     big_ext, small_xt, s2_sum_d;
    logic [SW-1:0]     s2_sum_q;
    logic              s2_vld_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zsign_q;
    logic [EXP_W-1:0]  s2_exp_q;

    always_comb begin
        big_ext  = {1'b0, s1_big_q, 3'b000};
        small_xt = {1'b0, s1_small_q};
        s2_sum_d = s1_sub_q ? (big_ext - small_xt) : (big_ext + small_xt);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_vld_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_sum_q   <= '0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zsign_q <= 1'b0;
        end else if (en) begin
            s2_vld_q   <= s1_vld_q;
            s2_sign_q  <= s1_sign_q;
            s2_exp_q   <= s1_exp_q;
            s2_sum_q   <= s2_sum_d;
            s2_nan_q   <= s1_nan_q;
            s2_inf_q   <= s1_inf_q;
            s2_zsign_q <= s1_zsign_q;
        end
    end

    // ------------------------------------------------------------------ S3 normalise / round
    logic [LZW-1:0]          lzc;
    logic [XW-1:0]           norm;
    logic                    is_zero;
    logic signed [EW-1:0]    exp_base, exp_n, exp_r;
    logic [MANT_W-1:0]       frac_r;
    logic [W-1:0]            out_sum_d;
    logic [1:0]              out_status_d;
`ifdef FP_SUM_RNE_EN
    logic                    round_up;
    logic [MANT_W+1:0]       rnd;
`endif

    logic                    out_vld_q;
    logic [W-1:0]            out_sum_q;
    logic [1:0]              out_status_q;

    always_comb begin
        lzc = LZW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (s2_sum_q[i]) lzc = LZW'(XW - 1 - i);
        end

        exp_base = $signed({2'b00, s2_exp_q});
        if (s2_sum_q[SW-1]) begin
            norm  = {s2_sum_q[SW-1:2], |s2_sum_q[1:0]};
            exp_n = exp_base + EXP_INC;
        end else begin
            norm  = s2_sum_q[XW-1:0] << lzc;
            exp_n = exp_base - $signed({{(EW-LZW){1'b0}}, lzc});
        end
        is_zero = ~|norm;

`ifdef FP_SUM_RNE_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[XW-1:3]} + {{(MANT_W+1){1'b0}}, round_up};
        if (rnd[MANT_W+1]) begin
            frac_r = rnd[MANT_W:1];
            exp_r  = exp_n + EXP_INC;
        end else begin
            frac_r = rnd[MANT_W-1:0];
            exp_r  = exp_n;
        end
`else
        frac_r = norm[XW-2:3];
        exp_r  = exp_n;
`endif

        if (s2_nan_q) begin
            out_sum_d    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            out_status_d = ST_NAN;
        end else if (s2_inf_q) begin
            out_sum_d    = {s2_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            out_status_d = ST_INF;
        end else if (is_zero) begin
            out_sum_d    = {s2_zsign_q, {(W-1){1'b0}}};
            out_status_d = ST_OK;
        end else if (exp_r >= EXP_ONES) begin
            out_sum_d    = {s2_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            out_status_d = ST_INF;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            out_sum_d    = {s2_sign_q, {(W-1){1'b0}}};
            out_status_d = ST_OK;
        end else begin
            out_sum_d    = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
            out_status_d = ST_OK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_vld_q    <= 1'b0;
            out_sum_q    <= '0;
            out_status_q <= ST_OK;
        end else if (en) begin
            out_vld_q    <= s2_vld_q;
            out_sum_q    <= out_sum_d;
            out_status_q <= out_status_d;
        end
    end

    assign en       = rdy_i | ~out_vld_q;
    assign rdy_o    = en;
    assign vld_o    = out_vld_q;
    assign sum_o    = out_sum_q;
    assign status_o = out_status_q;

endmodule

// File: tb/tb_pipe_fp_summator.sv
// Directed-vector bench for pipe_fp_summator (binary32): results, latency, stall ordering, reset flush.
module tb_pipe_fp_summator;

`ifdef FP_SUM_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        vld_i = 1'b0, rdy_i = 1'b1;
    logic        rdy_o, vld_o;
    logic [31:0] sum_o;
    logic [1:0]  status_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_fp_summator #(.EXP_W(8), .MANT_W(23)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_i(a_i), .b_i(b_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .sum_o(sum_o), .status_o(status_o), .vld_o(vld_o), .rdy_i(rdy_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One operation with rdy_i high; returns result and latency in clock edges from the accept edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] s, output logic [1:0] st, output int lat);
        @(negedge clk_i);
        a_i = a; b_i = b; vld_i = 1'b1;
        @(negedge clk_i);
        vld_i = 1'b0;
        lat = 1;
        while (!vld_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        s  = sum_o;
        st = status_o;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [1:0]  st;
        int          lat;
        logic [31:0] got[$];

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 2'b00};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 2'b00};
        vecs[2]  = '{32'h80000000, 32'h80000000, 32'h80000000, 2'b00};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 2'b01};
        vecs[4]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b10};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b10};
        vecs[6]  = '{32'h3F800000, 32'h33C00000, RNE ? 32'h3F800001 : 32'h3F800000, 2'b00};
        vecs[7]  = '{32'h40000000, 32'h3F800000, 32'h40400000, 2'b00};
        vecs[8]  = '{32'h3F800000, 32'hC0000000, 32'hBF800000, 2'b00};
        vecs[9]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 2'b01};
        vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 2'b01};
        vecs[11] = '{32'h00400000, 32'h3F800000, 32'h3F800000, 2'b00};
        vecs[12] = '{32'h00400000, 32'h80000001, 32'h00000000, 2'b00};
        vecs[13] = '{32'h40490FDB, 32'h00000000, 32'h40490FDB, 2'b00};
        vecs[14] = '{32'h00800001, 32'h80800000, 32'h00000000, 2'b00};
        vecs[15] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 2'b00};
        vecs[16] = '{32'h3F800001, 32'h33800000, RNE ? 32'h3F800002 : 32'h3F800001, 2'b00};
        vecs[17] = '{32'h3FFFFFFF, 32'h33C00000, RNE ? 32'h40000000 : 32'h3FFFFFFF, 2'b00};
        vecs[18] = '{32'h7F7FFFFF, 32'h73400000, RNE ? 32'h7F800000 : 32'h7F7FFFFF,
                     RNE ? 2'b01 : 2'b00};
        vecs[19] = '{32'h40000000, 32'hB3800000, RNE ? 32'h40000000 : 32'h3FFFFFFF, 2'b00};

        rdy_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset vld_o", 32'(vld_o), 32'd0);
        check("reset sum_o", sum_o, 32'h0);
        check("reset status_o", 32'(status_o), 32'd0);
        check("reset rdy_o", 32'(rdy_o), 32'd1);

        rdy_i = 1'b1;
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, s, st, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d sum", i), s, vecs[i].s);
            check($sformatf("vec%0d status", i), 32'(st), 32'(vecs[i].st));
        end

        // Three back-to-back operations, then the consumer stalls for 4 clocks.
        @(negedge clk_i);
        a_i = 32'h3F800000; b_i = 32'h3F800000; vld_i = 1'b1;
        @(negedge clk_i);
        a_i = 32'h40000000; b_i = 32'h3F800000;
        @(negedge clk_i);
        a_i = 32'h3F800000; b_i = 32'hC0000000;
        @(negedge clk_i);
        vld_i = 1'b0; rdy_i = 1'b0;
        check("stall head vld_o", 32'(vld_o), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check($sformatf("stall%0d vld_o", c), 32'(vld_o), 32'd1);
            check($sformatf("stall%0d sum_o", c), sum_o, 32'h40000000);
            check($sformatf("stall%0d rdy_o", c), 32'(rdy_o), 32'd0);
        end
        rdy_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (vld_o && rdy_i) got.push_back(sum_o);
            @(negedge clk_i);
        end
        check("stall drain count", 32'(got.size()), 32'd3);
        check("stall drain 0", got.size() > 0 ? got[0] : 32'hDEADDEAD, 32'h40000000);
        check("stall drain 1", got.size() > 1 ? got[1] : 32'hDEADDEAD, 32'h40400000);
        check("stall drain 2", got.size() > 2 ? got[2] : 32'hDEADDEAD, 32'hBF800000);

        // Fill the pipe against a stalled consumer, then pulse reset for one clock.
        rdy_i = 1'b0;
        a_i = 32'h3F800000; b_i = 32'h3F800000; vld_i = 1'b1;
        repeat (3) @(negedge clk_i);
        vld_i = 1'b0;
        check("full before reset vld_o", 32'(vld_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("after reset vld_o", 32'(vld_o), 32'd0);
        check("after reset sum_o", sum_o, 32'h0);
        check("after reset status_o", 32'(status_o), 32'd0);
        rdy_i = 1'b1;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (vld_o) lat++;
        end
        check("no stale results after reset", 32'(lat), 32'd0);

        // Pipe still usable after the flush.
        apply(32'h40000000, 32'h3F800000, s, st, lat);
        check("post-reset latency", 32'(lat), 32'd3);
        check("post-reset sum", s, 32'h40400000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
